// File: rtl/disp_sched_pkg.sv
// Shared definitions for the display scheduler: state codes, decimal-point
// patterns, the saturation ceiling and the saturation helper.
package disp_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FARE = 3'd1,
      ST_DIST = 3'd2,
      ST_TIME = 3'd3,
      ST_OVR  = 3'd4
   } state_e;

   localparam logic [5:0]  PT_FARE      = 6'b000100;
   localparam logic [5:0]  PT_DIST      = 6'b000010;
   localparam logic [5:0]  PT_TIME      = 6'b000000;
   localparam logic [5:0]  PT_NONE      = 6'b000000;
   localparam logic [19:0] MAX_DISP_DEF = 20'd999_999;

   // Clamp a 20-bit unsigned value to the six-digit display range.
   function automatic logic [19:0] sat20(input logic [19:0] x, input logic [19:0] max_val);
      return (x > max_val) ? max_val : x;
   endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// Loadable down-counter. tc is high while the count sits at zero, so a
// counter loaded with N-1 flags its terminal count N cycles after the load.
module disp_dwell_timer #(
   parameter int W = 8
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         load,
   input  logic         clr,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   // Count down towards zero and park there; load wins over clear.
   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments and a synchronous reset inside the clocked block.
      if (sys_rst)             count <= '0;
      else if (load)           count <= load_val;
      else if (clr)            count <= '0;
      else if (count != '0)    count <= count - W'(1);
   end

   assign tc = (count == '0);

endmodule

// File: rtl/disp_sched_ctrl.sv
// Display scheduler: rotates fare/distance/wait-time sources on a dwell timer
// or key press, and lets a priority override take the display for a fixed hold.
module disp_sched_ctrl
   import disp_sched_pkg::*;
#(
   parameter int          DWELL_CYC    = 150_000_000,
   parameter int          OVR_HOLD_CYC = 100_000_000,
   parameter logic [19:0] MAX_DISP     = MAX_DISP_DEF
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [19:0] fare_val,
   input  logic [19:0] dist_val,
   input  logic [19:0] time_val,
   input  logic [2:0]  src_valid,
   input  logic        key_next,
   input  logic        display_on,
   input  logic        ovr_req,
   input  logic [19:0] ovr_data,
   input  logic        ovr_sign,
   output logic        ovr_ack,
   output logic [19:0] data,
   output logic [5:0]  point,
   output logic        seg_en,
   output logic        sign,
   output logic [2:0]  cur_src
);

   localparam int DW = $clog2(DWELL_CYC);
   localparam int HW = $clog2(OVR_HOLD_CYC);
   localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(OVR_HOLD_CYC - 1);

   state_e      state, state_nx, saved_src;
   logic [19:0] ovr_lat_data;
   logic        ovr_lat_sign;
   logic        accept, dwell_load, dwell_clr, dwell_tc, hold_load, hold_clr, hold_tc;

   // First valid source strictly after cur in FARE->DIST->TIME order, wrapping
   // back to cur itself; IDLE and TIME both start the search at FARE.
   function automatic state_e next_src(input state_e cur, input logic [2:0] valid);
      state_e r;
      r = ST_IDLE;
      case (cur)
         ST_FARE: if (valid[1]) r = ST_DIST; else if (valid[2]) r = ST_TIME; else if (valid[0]) r = ST_FARE;
         ST_DIST: if (valid[2]) r = ST_TIME; else if (valid[0]) r = ST_FARE; else if (valid[1]) r = ST_DIST;
         default: if (valid[0]) r = ST_FARE; else if (valid[1]) r = ST_DIST; else if (valid[2]) r = ST_TIME;
      endcase
      return r;
   endfunction

   function automatic logic src_ok(input state_e s, input logic [2:0] valid);
      case (s)
         ST_FARE: return valid[0];
         ST_DIST: return valid[1];
         ST_TIME: return valid[2];
         default: return 1'b0;
      endcase
   endfunction

   // Next-state decision: override first, then invalidation, key and dwell expiry.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a latch behind.
      state_nx   = state;
      accept     = 1'b0;
      dwell_load = 1'b0;
      hold_clr   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (ovr_req) accept = 1'b1;
            else begin
               state_nx   = next_src(ST_IDLE, src_valid);
               dwell_load = 1'b1;
            end
         end
         ST_FARE, ST_DIST, ST_TIME: begin
            if (ovr_req) accept = 1'b1;
            else if (!src_ok(state, src_valid) || key_next || dwell_tc) begin
               state_nx   = next_src(state, src_valid);
               dwell_load = 1'b1;
            end
         end
         ST_OVR: begin
            if (hold_tc) begin
               state_nx   = src_ok(saved_src, src_valid) ? saved_src : next_src(saved_src, src_valid);
               dwell_load = 1'b1;
               hold_clr   = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (accept) state_nx = ST_OVR;
      hold_load = accept;
      dwell_clr = (state_nx == ST_IDLE);
   end

   disp_dwell_timer #(.W(DW)) u_dwell (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .load     (dwell_load && (state_nx != ST_IDLE)),
      .clr      (dwell_clr),
      .load_val (DWELL_LOAD),
      .tc       (dwell_tc)
   );

   disp_dwell_timer #(.W(HW)) u_hold (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .load     (hold_load),
      .clr      (hold_clr),
      .load_val (HOLD_LOAD),
      .tc       (hold_tc)
   );

   // FSM state, override capture and registered display outputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state        <= ST_IDLE;
         saved_src    <= ST_FARE;
         ovr_lat_data <= '0;
         ovr_lat_sign <= 1'b0;
         ovr_ack      <= 1'b0;
         data         <= '0;
         point        <= '0;
         sign         <= 1'b0;
         seg_en       <= 1'b0;
      end else begin
         state   <= state_nx;
         ovr_ack <= accept;
         if (accept) begin
            saved_src    <= (state == ST_IDLE) ? ST_FARE : state;
            ovr_lat_data <= ovr_data;
            ovr_lat_sign <= ovr_sign;
         end
         seg_en <= display_on && (state != ST_IDLE);
         unique case (state)
            ST_FARE: begin data <= sat20(fare_val, MAX_DISP);     point <= PT_FARE; sign <= 1'b0;         end
            ST_DIST: begin data <= sat20(dist_val, MAX_DISP);     point <= PT_DIST; sign <= 1'b0;         end
            ST_TIME: begin data <= sat20(time_val, MAX_DISP);     point <= PT_TIME; sign <= 1'b0;         end
            ST_OVR:  begin data <= sat20(ovr_lat_data, MAX_DISP); point <= PT_NONE; sign <= ovr_lat_sign; end
            default: begin data <= '0;                            point <= PT_NONE; sign <= 1'b0;         end
         endcase
      end
   end

   assign cur_src = state;

endmodule

// File: tb/tb_disp_sched_ctrl.sv
// Scoreboard bench for disp_sched_ctrl: a cycle model predicts each registered
// output set, pushes it when inputs are driven and compares it after the edge.
module tb_disp_sched_ctrl;

   localparam int D = 10;
   localparam int H = 6;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [19:0] fare_val, dist_val, time_val, ovr_data;
   logic [2:0]  src_valid;
   logic        key_next, display_on, ovr_req, ovr_sign;
   logic        ovr_ack, seg_en, sign;
   logic [19:0] data;
   logic [5:0]  point;
   logic [2:0]  cur_src;

   typedef struct {
      logic [2:0]  cur;
      logic [19:0] data;
      logic [5:0]  point;
      logic        sign;
      logic        seg_en;
      logic        ack;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   ack_seen = 0;

   // model state
   logic [2:0]  m_state = 3'd0;
   logic [2:0]  m_saved = 3'd1;
   int          m_cnt = 0;
   int          m_hold = 0;
   logic [19:0] m_lat_d = '0;
   logic        m_lat_s = 1'b0;

   always #5 sys_clk = ~sys_clk;

   disp_sched_ctrl #(.DWELL_CYC(D), .OVR_HOLD_CYC(H)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .fare_val   (fare_val),
      .dist_val   (dist_val),
      .time_val   (time_val),
      .src_valid  (src_valid),
      .key_next   (key_next),
      .display_on (display_on),
      .ovr_req    (ovr_req),
      .ovr_data   (ovr_data),
      .ovr_sign   (ovr_sign),
      .ovr_ack    (ovr_ack),
      .data       (data),
      .point      (point),
      .seg_en     (seg_en),
      .sign       (sign),
      .cur_src    (cur_src)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [19:0] m_sat(input logic [19:0] x);
      return (x > 20'd999999) ? 20'd999999 : x;
   endfunction

   // Walk the rotation one step at a time from cur; cur itself is the last candidate.
   function automatic logic [2:0] m_next(input logic [2:0] cur, input logic [2:0] v);
      logic [2:0] c;
      logic [2:0] r;
      c = cur;
      r = 3'd0;
      for (int k = 0; k < 3; k++) begin
         c = (c == 3'd3) ? 3'd1 : c + 3'd1;
         if (r == 3'd0 && v[c - 3'd1]) r = c;
      end
      return r;
   endfunction

   task automatic model_step();
      exp_t       e;
      logic [2:0] s;
      logic       acc;
      s = m_state;
      acc = 1'b0;
      e.cur = 3'd0; e.data = '0; e.point = '0; e.sign = 1'b0; e.seg_en = 1'b0; e.ack = 1'b0;
      if (sys_rst) begin
         m_state = 3'd0; m_cnt = 0; m_hold = 0; m_saved = 3'd1;
      end else begin
         e.seg_en = display_on && (s != 3'd0);
         case (s)
            3'd1: begin e.data = m_sat(fare_val); e.point = 6'b000100; end
            3'd2: begin e.data = m_sat(dist_val); e.point = 6'b000010; end
            3'd3: begin e.data = m_sat(time_val); end
            3'd4: begin e.data = m_sat(m_lat_d); e.sign = m_lat_s; end
            default: ;
         endcase
         if (s != 3'd4 && ovr_req) acc = 1'b1;
         else if (s == 3'd0) begin
            m_state = m_next(3'd3, src_valid); m_cnt = 0;
         end else if (s == 3'd4) begin
            if (m_hold == H - 1) begin
               m_state = src_valid[m_saved - 3'd1] ? m_saved : m_next(m_saved, src_valid);
               m_cnt = 0;
            end else m_hold++;
         end else if (!src_valid[s - 3'd1] || key_next || m_cnt == D - 1) begin
            m_state = m_next(s, src_valid); m_cnt = 0;
         end else m_cnt++;
         if (acc) begin
            m_saved = (s == 3'd0) ? 3'd1 : s;
            m_lat_d = ovr_data; m_lat_s = ovr_sign;
            m_state = 3'd4; m_hold = 0; e.ack = 1'b1;
         end
         e.cur = m_state;
      end
      exp_q.push_back(e);
   endtask

   task automatic tick();
      exp_t g;
      model_step();
      @(posedge sys_clk);
      #1;
      g = exp_q.pop_front();
      check("cur_src", 32'(cur_src), 32'(g.cur));
      check("data",    32'(data),    32'(g.data));
      check("point",   32'(point),   32'(g.point));
      check("sign",    32'(sign),    32'(g.sign));
      check("seg_en",  32'(seg_en),  32'(g.seg_en));
      check("ovr_ack", 32'(ovr_ack), 32'(g.ack));
      if (ovr_ack === 1'b1) ack_seen++;
   endtask

   task automatic run_until(input logic [2:0] tgt, input string tag);
      int n;
      n = 0;
      while (m_state != tgt && n < 60) begin tick(); n++; end
      check(tag, 32'(cur_src), 32'(tgt));
   endtask

   initial begin
      sys_rst = 1'b1; fare_val = '0; dist_val = '0; time_val = '0; ovr_data = '0;
      src_valid = '0; key_next = 1'b0; display_on = 1'b1; ovr_req = 1'b0; ovr_sign = 1'b0;

      // 1: reset, then first source
      repeat (3) tick();
      check("reset_cur_src", 32'(cur_src), 0);
      check("reset_data", 32'(data), 0);
      sys_rst = 1'b0; src_valid = 3'b111;
      fare_val = 20'd1234; dist_val = 20'd567; time_val = 20'd89;
      tick(); tick();
      check("first_data", 32'(data), 1234);
      check("first_seg_en", 32'(seg_en), 1);

      // 2: rotation with skip, key mid-dwell, key on expiry
      src_valid = 3'b101;
      repeat (25) tick();
      run_until(3'd1, "wait_fare");
      repeat (3) tick();
      key_next = 1'b1; tick(); key_next = 1'b0;
      check("key_mid", 32'(cur_src), 3);
      for (int n = 0; n < 20 && m_cnt != D - 1; n++) tick();
      key_next = 1'b1; tick(); key_next = 1'b0;
      check("key_expiry", 32'(cur_src), 1);
      tick();
      check("key_once", 32'(cur_src), 1);

      // 3: override in DIST, request held across the whole hold
      src_valid = 3'b111;
      run_until(3'd2, "wait_dist");
      ovr_req = 1'b1; ovr_data = 20'd42; ovr_sign = 1'b1; ack_seen = 0;
      tick();
      check("ovr_ack_entry", 32'(ovr_ack), 1);
      tick();
      check("ovr_data", 32'(data), 42);
      check("ovr_sign", 32'(sign), 1);
      repeat (6) tick();
      ovr_req = 1'b0;
      check("ovr_ack_count", 32'(ack_seen), 2);
      repeat (20) tick();

      // 4: saturation, invalidation, all sources off
      fare_val = 20'hFFFFF;
      run_until(3'd1, "wait_fare_sat");
      tick();
      check("sat", 32'(data), 999999);
      src_valid = 3'b110; tick();
      check("invalidate", 32'(cur_src), 2);
      repeat (3) tick();
      src_valid = 3'b000; tick(); tick();
      check("idle_cur", 32'(cur_src), 0);
      check("idle_seg_en", 32'(seg_en), 0);
      check("idle_data", 32'(data), 0);

      // 5: display off keeps rotating; reset in the middle of an override
      src_valid = 3'b111; fare_val = 20'd1234; display_on = 1'b0;
      repeat (25) tick();
      check("seg_en_off", 32'(seg_en), 0);
      display_on = 1'b1;
      ovr_req = 1'b1; ovr_data = 20'd777; ovr_sign = 1'b0;
      repeat (3) tick();
      sys_rst = 1'b1; tick();
      check("rst_mid_cur", 32'(cur_src), 0);
      check("rst_mid_ack", 32'(ovr_ack), 0);
      check("rst_mid_data", 32'(data), 0);
      sys_rst = 1'b0; tick();
      check("rearb_ack", 32'(ovr_ack), 1);
      ovr_req = 1'b0;
      repeat (10) tick();

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if (i % 23 == 0) src_valid = 3'($urandom_range(0, 7));
         if (i % 37 == 0) display_on = 1'($urandom_range(0, 1));
         fare_val = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 999999));
         dist_val = 20'($urandom);
         time_val = 20'($urandom_range(0, 5000));
         key_next = ($urandom_range(0, 7) == 0);
         if (!ovr_req && $urandom_range(0, 15) == 0) begin
            ovr_req = 1'b1; ovr_data = 20'($urandom); ovr_sign = 1'($urandom_range(0, 1));
         end
         sys_rst = ($urandom_range(0, 149) == 0);
         tick();
         if (ovr_ack === 1'b1) ovr_req = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
